// File: rtl/booth_product_accum.sv
// booth_product_accum: sums blocks of BLOCK_LEN signed Booth products and
// hands each block sum downstream over a valid/accept handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   prod_in             signed product from the multiplier (2*OPERAND_BITS)
//   prod_ready          multiplier done level; rising edge = new product
//   clear               synchronous flush of all accumulation state
//   acc_out             signed block sum (ACC_BITS), stable while acc_valid
//   acc_valid           block result available
//   acc_accept          downstream takes result on acc_valid && acc_accept
//   count               products absorbed into the current block
//   overflow            sticky signed overflow within the current block
//   dropped             sticky: a product was lost (pending buffer full)
//
// Build option:
//   BOOTH_ACC_SAT_EN    when defined, overflowing adds clamp to the signed
//                       range instead of wrapping.
module booth_product_accum #(
    parameter int OPERAND_BITS = 4,
    parameter int ACC_BITS     = 16,
    parameter int BLOCK_LEN    = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [2*OPERAND_BITS-1:0]        prod_in,
    input  logic                             prod_ready,
    input  logic                             clear,
    output logic [ACC_BITS-1:0]              acc_out,
    output logic                             acc_valid,
    input  logic                             acc_accept,
    output logic [$clog2(BLOCK_LEN+1)-1:0]   count,
    output logic                             overflow,
    output logic                             dropped
);

    localparam int PW = 2 * OPERAND_BITS;
    localparam int CW = $clog2(BLOCK_LEN + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(BLOCK_LEN);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ACC_BITS-1:0] acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                drop_q, drop_d;
    logic                pend_v_q, pend_v_d;
    logic [PW-1:0]       pend_q, pend_d;
    logic                rdy_q;

    logic                cap;
    logic [ACC_BITS-1:0] add_b;
    logic [ACC_BITS-1:0] add_raw;
    logic                add_ovf;
    logic [ACC_BITS-1:0] add_res;
    logic [CW-1:0]       cnt_inc;

    function automatic logic [ACC_BITS-1:0] sext(input logic [PW-1:0] p);
        return ACC_BITS'($signed(p));
    endfunction

    // New product only on the rising edge of the done level.
    assign cap = prod_ready & ~rdy_q;

    // A waiting pending product always goes in ahead of a fresh capture,
    // so the adder operand is the pending entry whenever one exists.
    assign add_b   = pend_v_q ? sext(pend_q) : sext(prod_in);
    assign add_raw = acc_q + add_b;
    assign add_ovf = (acc_q[ACC_BITS-1] == add_b[ACC_BITS-1]) &&
                     (add_raw[ACC_BITS-1] != acc_q[ACC_BITS-1]);

`ifdef BOOTH_ACC_SAT_EN
    localparam logic [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
    localparam logic [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

    // Overflow direction follows the sign both operands share.
    always_comb begin
        add_res = add_raw;
        if (add_ovf) begin
            add_res = acc_q[ACC_BITS-1] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    assign add_res = add_raw;
`endif

    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        pend_v_d = pend_v_q;
        pend_d   = pend_q;

        if (clear) begin
            state_d  = ST_ACCUM;
            acc_d    = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            drop_d   = 1'b0;
            pend_v_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_ACCUM: begin
                    if (pend_v_q || cap) begin
                        acc_d = add_res;
                        ovf_d = ovf_q | add_ovf;
                        cnt_d = cnt_inc;
                        // Draining pending frees the slot for this cycle's cap.
                        if (pend_v_q) begin
                            pend_v_d = cap;
                            if (cap) begin
                                pend_d = prod_in;
                            end
                        end
                        if (cnt_inc == CNT_FULL) begin
                            state_d = ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (acc_accept) begin
                        ovf_d = 1'b0;
                        if (pend_v_q) begin
                            acc_d = sext(pend_q);
                            cnt_d = CNT_ONE;
                            state_d = (CNT_ONE == CNT_FULL) ? ST_HOLD : ST_ACCUM;
                        end else begin
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = ST_ACCUM;
                        end
                        pend_v_d = cap;
                        if (cap) begin
                            pend_d = prod_in;
                        end
                    end else if (cap) begin
                        if (pend_v_q) begin
                            drop_d = 1'b1;
                        end else begin
                            pend_v_d = 1'b1;
                            pend_d   = prod_in;
                        end
                    end
                end

                default: begin
                    state_d = ST_ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ACCUM;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= 1'b0;
            pend_v_q <= 1'b0;
            pend_q   <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
            // Tracks the level even during clear so a held level is ignored.
            rdy_q    <= prod_ready;
        end
    end

    assign acc_out   = acc_q;
    assign acc_valid = (state_q == ST_HOLD);
    assign count     = cnt_q;
    assign overflow  = ovf_q;
    assign dropped   = drop_q;

endmodule

// File: tb/tb_booth_product_accum.sv
// tb_booth_product_accum: directed and random checks of booth_product_accum
// against a transaction-level model, for three parameter sets.
module tb_booth_product_accum;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       prod_ready = 1'b0;
    logic       clear = 1'b0;
    logic       acc_accept = 1'b0;
    logic [7:0] prod_in = '0;

    logic [15:0] acc0;
    logic [7:0]  acc1;
    logic [15:0] acc2;
    logic        v0, v1, v2;
    logic [2:0]  c0, c1;
    logic [0:0]  c2;
    logic        o0, o1, o2;
    logic        d0, d1, d2;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    booth_product_accum #(.OPERAND_BITS(4), .ACC_BITS(16), .BLOCK_LEN(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_ready(prod_ready),
        .clear(clear), .acc_out(acc0), .acc_valid(v0), .acc_accept(acc_accept),
        .count(c0), .overflow(o0), .dropped(d0));

    booth_product_accum #(.OPERAND_BITS(4), .ACC_BITS(8), .BLOCK_LEN(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_ready(prod_ready),
        .clear(clear), .acc_out(acc1), .acc_valid(v1), .acc_accept(acc_accept),
        .count(c1), .overflow(o1), .dropped(d1));

    booth_product_accum #(.OPERAND_BITS(4), .ACC_BITS(16), .BLOCK_LEN(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_ready(prod_ready),
        .clear(clear), .acc_out(acc2), .acc_valid(v2), .acc_accept(acc_accept),
        .count(c2), .overflow(o2), .dropped(d2));

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int MW[3] = '{16, 8, 16};
    int MB[3] = '{4, 4, 1};
    int m_acc[3];
    int m_cnt[3];
    int m_pend[3];
    bit m_hold[3];
    bit m_pv[3];
    bit m_ovf[3];
    bit m_drop[3];
    bit m_prev;

    task automatic m_reset();
        m_prev = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_pend[i] = 0;
            m_hold[i] = 0; m_pv[i] = 0; m_ovf[i] = 0; m_drop[i] = 0;
        end
    endtask

    task automatic m_add(input int i, input int p);
        int r, lo, hi;
        r  = m_acc[i] + p;
        hi = (1 << (MW[i] - 1)) - 1;
        lo = -(1 << (MW[i] - 1));
        if (r > hi || r < lo) begin
            m_ovf[i] = 1'b1;
`ifdef BOOTH_ACC_SAT_EN
            r = (r > hi) ? hi : lo;
`else
            r = (r > hi) ? r - (1 << MW[i]) : r + (1 << MW[i]);
`endif
        end
        m_acc[i] = r;
    endtask

    task automatic m_step();
        bit cap;
        int p;
        cap = prod_ready && !m_prev;
        p = int'($signed(prod_in));
        m_prev = prod_ready;
        for (int i = 0; i < 3; i++) begin
            if (clear) begin
                m_acc[i] = 0; m_cnt[i] = 0; m_hold[i] = 0;
                m_pv[i] = 0; m_ovf[i] = 0; m_drop[i] = 0;
            end else if (m_hold[i]) begin
                if (acc_accept) begin
                    m_ovf[i] = 0;
                    if (m_pv[i]) begin
                        m_acc[i] = m_pend[i];
                        m_cnt[i] = 1;
                    end else begin
                        m_acc[i] = 0;
                        m_cnt[i] = 0;
                    end
                    m_pv[i] = cap;
                    if (cap) m_pend[i] = p;
                    m_hold[i] = (m_cnt[i] == MB[i]);
                end else if (cap) begin
                    if (m_pv[i]) m_drop[i] = 1;
                    else begin m_pv[i] = 1; m_pend[i] = p; end
                end
            end else begin
                if (m_pv[i]) begin
                    m_add(i, m_pend[i]);
                    m_cnt[i]++;
                    m_pv[i] = cap;
                    if (cap) m_pend[i] = p;
                end else if (cap) begin
                    m_add(i, p);
                    m_cnt[i]++;
                end
                m_hold[i] = (m_cnt[i] == MB[i]);
            end
        end
    endtask

    task automatic cmp(input int i, input logic v, input int a,
                       input int c, input logic o, input logic d);
        chk($sformatf("i%0d_valid", i), int'(v), int'(m_hold[i]));
        chk($sformatf("i%0d_acc", i), a, m_acc[i]);
        chk($sformatf("i%0d_count", i), c, m_cnt[i]);
        chk($sformatf("i%0d_ovf", i), int'(o), int'(m_ovf[i]));
        chk($sformatf("i%0d_drop", i), int'(d), int'(m_drop[i]));
    endtask

    always @(negedge clk) begin
        if (!rst_n) m_reset();
        cmp(0, v0, int'($signed(acc0)), int'(c0), o0, d0);
        cmp(1, v1, int'($signed(acc1)), int'(c1), o1, d1);
        cmp(2, v2, int'($signed(acc2)), int'(c2), o2, d2);
        if (rst_n) m_step();
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int p, input int hold);
        prod_in = 8'(p);
        prod_ready = 1'b1;
        repeat (hold) tick();
        prod_ready = 1'b0;
        tick();
    endtask

    task automatic accept();
        acc_accept = 1'b1;
        tick();
        acc_accept = 1'b0;
    endtask

    initial begin
        tick();
        chk("rst_acc", int'(acc0), 0);
        chk("rst_valid", int'(v0), 0);
        chk("rst_count", int'(c0), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // overflow block: 64,64,-8,1
        pulse(64, 3); pulse(64, 3); pulse(-8, 3); pulse(1, 3);
        chk("A_acc16", int'($signed(acc0)), 121);
        chk("A_ovf16", int'(o0), 0);
        chk("A_valid8", int'(v1), 1);
`ifdef BOOTH_ACC_SAT_EN
        chk("A_acc8", int'($signed(acc1)), 120);
`else
        chk("A_acc8", int'($signed(acc1)), 121);
`endif
        chk("A_ovf8", int'(o1), 1);
        chk("A_acc_bl1", int'($signed(acc2)), 64);
        chk("A_drop_bl1", int'(d2), 1);
        accept();

        // 6,-8,64,-56 with one-cycle latency on the last capture
        pulse(6, 3); pulse(-8, 3); pulse(64, 3);
        prod_in = 8'(-56);
        prod_ready = 1'b1;
        chk("B_pre_valid", int'(v0), 0);
        tick();
        chk("B_valid", int'(v0), 1);
        chk("B_acc", int'($signed(acc0)), 6);
        chk("B_ovf", int'(o0), 0);
        chk("B_count", int'(c0), 4);
        tick(); tick();
        prod_ready = 1'b0;
        tick();
        accept();
        chk("B_acc_valid_after", int'(v0), 0);
        chk("B_count_after", int'(c0), 0);

        // held level captures only once
        prod_in = 8'd9;
        prod_ready = 1'b1;
        repeat (20) tick();
        prod_ready = 1'b0;
        tick();
        pulse(9, 2);
        chk("C_count", int'(c0), 2);
        pulse(1, 1); pulse(1, 1);
        chk("C_acc", int'($signed(acc0)), 20);
        accept();

        // pending buffer and drop
        pulse(10, 2); pulse(20, 2); pulse(30, 2); pulse(40, 2);
        pulse(5, 2); pulse(7, 2);
        chk("D_acc", int'($signed(acc0)), 100);
        chk("D_drop", int'(d0), 1);
        accept();
        chk("D_count", int'(c0), 1);
        chk("D_acc_pend", int'($signed(acc0)), 5);
        pulse(1, 2); pulse(2, 2); pulse(3, 2);
        chk("D_acc2", int'($signed(acc0)), 11);
        accept();

        // clear while prod_ready held high
        pulse(3, 2);
        prod_in = 8'd4;
        prod_ready = 1'b1;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("E_count", int'(c0), 0);
        chk("E_acc", int'($signed(acc0)), 0);
        chk("E_drop", int'(d0), 0);
        tick(); tick();
        chk("E_norecap", int'(c0), 0);
        prod_ready = 1'b0;
        tick();
        repeat (4) pulse(1, 2);
        chk("E_acc4", int'($signed(acc0)), 4);
        accept();

        // reset mid-block
        pulse(2, 2); pulse(2, 2); pulse(2, 2);
        chk("F_count3", int'(c0), 3);
        rst_n = 1'b0;
        #1;
        chk("F_rst_acc", int'(acc0), 0);
        chk("F_rst_count", int'(c0), 0);
        chk("F_rst_valid", int'(v0), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        repeat (4) pulse(2, 2);
        chk("F_acc8", int'($signed(acc0)), 8);
        accept();

        // random traffic
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                if (!prod_ready)
                    prod_in = 8'((int'($urandom_range(0, 15)) - 8) *
                                 (int'($urandom_range(0, 15)) - 8));
                prod_ready = ~prod_ready;
            end
            acc_accept = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 79) == 0);
            tick();
        end
        acc_accept = 1'b0;
        clear = 1'b0;
        prod_ready = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
